// File: rtl/fifo_rr_arbiter.sv
// Purpose : round-robin push-side arbiter sharing one fifo_flops between NREQ producers.
// Latency : req sampled at edge t -> gnt/fifo_push/fifo_Din valid during t..t+1, stored by FIFO at t+1.
// Backpr. : own occupancy credit counter; no grant when no slot is free after this edge's pop_ack.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset (shared with the FIFO)
//   req, din        per-producer request and word; producer i uses din[i*BITS +: BITS]
//   gnt             registered one-hot pulse: "your word was taken"
//   fifo_Din/push   registered FIFO write port
//   pop_ack         accepted pop at the FIFO (pop & pndng)
//   level, full_cr  credit occupancy 0..DEPTH, and level == DEPTH
module fifo_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int BITS  = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] din,
  output logic [NREQ-1:0]      gnt,
  output logic [BITS-1:0]      fifo_Din,
  output logic                 fifo_push,
  input  logic                 pop_ack,
  output logic [CW-1:0]        level,
  output logic                 full_cr
);

  localparam int PW = $clog2(NREQ);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  logic          grant;
  logic          pop_ok;
  logic [CW-1:0] eff;
  logic [CW-1:0] level_nxt;

  // Rotating scan starting at ptr; first requester found wins.
  always_comb begin : pick
    int            idx;
    logic [PW-1:0] sel;
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  // A pop at level 0 has no credit to return and is ignored. The pop frees
  // its slot for the grant decision on the same edge, so a full FIFO with a
  // simultaneous pop still accepts one word.
  always_comb begin
    pop_ok    = pop_ack && (level != '0);
    eff       = level - CW'(pop_ok);
    grant     = found && (eff < DEPTH_C);
    level_nxt = grant ? eff + CW'(1) : eff;
    ptr_nxt   = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      fifo_push <= 1'b0;
      fifo_Din  <= '0;
      ptr       <= '0;
      level     <= '0;
      full_cr   <= 1'b0;
    end else begin
      level   <= level_nxt;
      full_cr <= (level_nxt == DEPTH_C);
      if (grant) begin
        gnt       <= NREQ'(1) << winner;
        fifo_push <= 1'b1;
        fifo_Din  <= din[int'(winner)*BITS +: BITS];
        ptr       <= ptr_nxt;
      end else begin
        // fifo_Din and ptr hold their values when idle.
        gnt       <= '0;
        fifo_push <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int BITS  = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NV    = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*BITS-1:0] din;
  logic [NREQ-1:0]      gnt;
  logic [BITS-1:0]      fifo_Din;
  logic                 fifo_push;
  logic                 pop_ack;
  logic [CW-1:0]        level;
  logic                 full_cr;

  fifo_rr_arbiter #(.NREQ(NREQ), .BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .fifo_Din (fifo_Din),
    .fifo_push(fifo_push),
    .pop_ack  (pop_ack),
    .level    (level),
    .full_cr  (full_cr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic [3:0]      req;
    logic            pop;
    logic [3:0]      gnt;
    logic            push;
    logic [15:0]     dat;
    logic [4:0]      lvl;
  } vec_t;

  vec_t        tbl [NV];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] fq[$];     // model of the FIFO behind the arbiter
  logic [15:0] expq[$];   // words the bench expects to pop, in order
  bit          score_on;
  logic        prev_push;
  logic [15:0] prev_din;
  int          kc [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock: inputs already driven, sample #1 after the edge, advance the FIFO model.
  task automatic step();
    logic        p;
    logic        r;
    logic [15:0] w;
    logic [15:0] e;
    p = pop_ack;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      fq.delete();
    end else begin
      if (p && fq.size() > 0) begin
        w = fq.pop_front();
        if (score_on) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_data at %0t: got 0x%0h, want nothing queued", $time, w);
          end else begin
            e = expq.pop_front();
            chk("pop_data", 32'(w), 32'(e));
          end
        end
      end
      if (prev_push) fq.push_back(prev_din);
    end
    prev_push = fifo_push;
    prev_din  = fifo_Din;
    // credit counts stored words plus the one in flight
    chk("credit_vs_fifo", 32'(level), 32'(fq.size()) + 32'(fifo_push));
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    din[i*BITS +: BITS] = w;
  endtask

  initial begin
    int          pushes;
    int          wi;
    logic [15:0] word;
    logic [4:0]  lvl_before;
    logic        pop_before;

    rst = 1'b1; req = '0; pop_ack = 1'b0; din = '0;
    score_on = 1'b0; prev_push = 1'b0; prev_din = '0;

    // ---------------- table-driven vectors (din fixed at 1111,2222,3333,4444) ----------------
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'h0000, 5'd0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 16'h1111, 5'd1};
    tbl[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 16'h3333, 5'd2};
    tbl[7]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 16'h1111, 5'd3};
    tbl[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1111, 5'd2};
    tbl[9]  = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 16'h4444, 5'd2};
    tbl[10] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 16'h1111, 5'd3};
    tbl[11] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 16'h2222, 5'd3};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h2222, 5'd2};
    tbl[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h2222, 5'd1};
    tbl[14] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h2222, 5'd0};
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h2222, 5'd0};
    tbl[16] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'h0000, 5'd0};
    tbl[17] = '{1'b0, 4'b0110, 1'b0, 4'b0010, 1'b1, 16'h2222, 5'd1};
    tbl[18] = '{1'b0, 4'b0110, 1'b0, 4'b0100, 1'b1, 16'h3333, 5'd2};
    tbl[19] = '{1'b0, 4'b0110, 1'b0, 4'b0010, 1'b1, 16'h2222, 5'd3};

    for (int i = 0; i < NREQ; i++) set_word(i, 16'h1111 * 16'(i + 1));
    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; pop_ack = tbl[i].pop;
      step();
      chk("tbl_gnt",   32'(gnt),       32'(tbl[i].gnt));
      chk("tbl_push",  32'(fifo_push), 32'(tbl[i].push));
      chk("tbl_din",   32'(fifo_Din),  32'(tbl[i].dat));
      chk("tbl_level", 32'(level),     32'(tbl[i].lvl));
      chk("tbl_full",  32'(full_cr),   32'(tbl[i].lvl == 5'd16));
    end

    // ---------------- round-robin fill to full, then drain in grant order ----------------
    rst = 1'b1; req = '0; pop_ack = 1'b0;
    step(); step();
    rst = 1'b0; expq.delete(); score_on = 1'b1;
    for (int i = 0; i < 4; i++) kc[i] = 0;
    req = 4'b1111;
    for (int n = 0; n < 19; n++) begin
      for (int i = 0; i < 4; i++) set_word(i, 16'(i << 8) + 16'(kc[i]));
      step();
      if (n < 16) begin
        wi   = n % 4;
        word = 16'(wi << 8) + 16'(n / 4);
        expq.push_back(word);
        chk("rr_gnt",   32'(gnt),      32'(4'b0001 << wi));
        chk("rr_din",   32'(fifo_Din), 32'(word));
        chk("rr_level", 32'(level),    32'(n + 1));
      end else begin
        chk("full_push",  32'(fifo_push), 32'd0);
        chk("full_level", 32'(level),     32'd16);
        chk("full_cr",    32'(full_cr),   32'd1);
      end
      for (int i = 0; i < 4; i++) if (gnt[i]) kc[i]++;
    end
    chk("fifo_count_full", 32'(fq.size()), 32'd16);
    req = '0; pop_ack = 1'b1;
    for (int n = 0; n < 16; n++) begin
      step();
      chk("drain_level", 32'(level), 32'(15 - n));
    end
    pop_ack = 1'b0;
    chk("drain_all_popped", 32'(expq.size()), 32'd0);

    // ---------------- overflow guard: req=0101 for 40 cycles, no pops ----------------
    rst = 1'b1; step(); rst = 1'b0;
    expq.delete(); kc[0] = 0; kc[2] = 0; pushes = 0;
    req = 4'b0101;
    for (int n = 0; n < 40; n++) begin
      set_word(0, 16'hB000 + 16'(kc[0]));
      set_word(2, 16'hB200 + 16'(kc[2]));
      lvl_before = level; pop_before = pop_ack;
      step();
      if (fifo_push) pushes++;
      if (lvl_before == 5'd16 && !pop_before) chk("no_push_at_full", 32'(fifo_push), 32'd0);
      if (n < 16) expq.push_back(16'hB000 + 16'(((n % 2) * 2) << 8) + 16'(n / 2));
      if (gnt[0]) kc[0]++;
      if (gnt[2]) kc[2]++;
    end
    chk("ovf_pushes", 32'(pushes),    32'd16);
    chk("ovf_level",  32'(level),     32'd16);
    chk("ovf_count",  32'(fq.size()), 32'd16);

    // ---------------- full with simultaneous pop ----------------
    req = 4'b0001; pop_ack = 1'b1;
    for (int n = 0; n < 8; n++) begin
      set_word(0, 16'hC000 + 16'(n));
      step();
      chk("fp_gnt",   32'(gnt),      32'b0001);
      chk("fp_level", 32'(level),    32'd16);
      chk("fp_din",   32'(fifo_Din), 32'hC000 + 32'(n));
      expq.push_back(16'hC000 + 16'(n));
    end
    req = '0;
    for (int n = 0; n < 16; n++) step();
    chk("fp_drain_level", 32'(level),       32'd0);
    chk("fp_drain_order", 32'(expq.size()), 32'd0);

    // ---------------- underflow guard ----------------
    for (int n = 0; n < 20; n++) begin
      step();
      chk("uf_level", 32'(level), 32'd0);
      chk("uf_gnt",   32'(gnt),   32'd0);
    end
    pop_ack = 1'b0;

    // ---------------- mid-operation reset at level 7 ----------------
    score_on = 1'b0;
    for (int i = 0; i < NREQ; i++) set_word(i, 16'hD000 + 16'(i << 4));
    req = 4'b0110;
    for (int n = 0; n < 7; n++) step();
    chk("mr_level7", 32'(level), 32'd7);
    req = 4'b1111; rst = 1'b1;
    step();
    chk("mr_level", 32'(level),     32'd0);
    chk("mr_gnt",   32'(gnt),       32'd0);
    chk("mr_push",  32'(fifo_push), 32'd0);
    chk("mr_din",   32'(fifo_Din),  32'd0);
    chk("mr_full",  32'(full_cr),   32'd0);
    rst = 1'b0;
    step();
    chk("mr_first_gnt", 32'(gnt),       32'b0001);
    chk("mr_first_din", 32'(fifo_Din),  32'hD000);
    chk("mr_level1",    32'(level),     32'd1);
    chk("mr_pndng0",    32'(fq.size()), 32'd0);
    step();
    chk("mr_second_gnt", 32'(gnt),       32'b0010);
    chk("mr_landed",     32'(fq.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin push-side arbiter that shares one `fifo_flops` instance between `NREQ` producers. Each cycle it picks at most one requesting producer and presents its word to the FIFO's `Din`/`push` inputs through registered outputs. It keeps its own occupancy credit counter, so it never pushes into a full FIFO. It sits directly in front of `fifo_flops` and shares that FIFO's clock and reset.

## Interface

- `NREQ`, default 4: number of producers, 2..8.
- `BITS`, default 16: data word width; must match the FIFO's `BITS`.
- `DEPTH`, default 16: FIFO depth; must match the FIFO's `DEPTH`.
- `CW`, default $clog2(DEPTH+1): occupancy counter width (derived, do not override).

Ports:

- `clk` input 1: single clock, all state on posedge.
- `rst` input 1: synchronous, active-high reset; the same net drives the FIFO's `rst`.
- `req` input NREQ: per-producer request; held high, with data stable, until granted.
- `din` input NREQ*BITS: producer words; producer i drives `din[i*BITS +: BITS]`.
- `gnt` output NREQ: registered one-hot grant pulse, one cycle, meaning "your word was taken".
- `fifo_Din` output BITS: registered; connects to FIFO `Din`.
- `fifo_push` output 1: registered; connects to FIFO `push`.
- `pop_ack` input 1: a pop accepted by the FIFO, i.e. the consumer's `pop & pndng`.
- `level` output CW: credit occupancy, 0..DEPTH.
- `full_cr` output 1: high when `level == DEPTH`.

## Operation

State:
- `ptr` (priority pointer), 0..NREQ-1.
- `level`, 0..DEPTH.
- Output registers `gnt`, `fifo_push`, `fifo_Din`.

Per posedge, when `rst == 0`:
- Effective occupancy: `eff = level - (pop_ack && level != 0)`. A `pop_ack` while `level == 0` is ignored (underflow guard).
- Winner: the first i with `req[i] == 1`, scanning `ptr`, `ptr+1`, … wrapping modulo NREQ.
- A grant happens only when a winner exists and `eff < DEPTH`.
- On a grant:
  - `gnt <= onehot(winner)`, `fifo_push <= 1`, `fifo_Din <= din[winner]`.
  - `ptr <= (winner+1) mod NREQ`.
  - `level <= eff + 1`.
- With no grant:
  - `gnt <= 0`, `fifo_push <= 0`, `level <= eff`.
  - `fifo_Din` holds its last value.
  - `ptr` is unchanged.
- After a grant pulse, the producer either drops `req` or presents its next word in the following cycle. A request that is still high is treated as a new word.
- Simultaneous grant and `pop_ack` at `level == DEPTH`: the pop frees a slot, so the grant is allowed and `level` stays at DEPTH.
- `level` counts the word pending in `fifo_push`, so `level` is never below the FIFO's real count. Worst-case lag is 1.

Reset (`rst == 1` at a posedge), including mid-operation:
- `gnt = 0`, `fifo_push = 0`, `fifo_Din = 0`, `ptr = 0`, `level = 0`, `full_cr = 0`.
- Any pending or in-flight word is dropped; the FIFO is cleared by the same `rst`.

## Timing

- Latency: `req` sampled at edge t → `gnt` and `fifo_push` high during cycle t..t+1 → the FIFO stores the word at edge t+1.
- Throughput: one word per cycle while `eff < DEPTH`.
- `full_cr` and `level` are registered and reflect state after the last edge.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0. No producer waits more than NREQ-1 grants.
- `pop_ack` at edge t frees its credit for the grant decision at that same edge t.

## Test plan

- **Reset:** hold `rst` for 5 cycles with `req=4'b1111` → `gnt=0`, `fifo_push=0`, `level=0` throughout; first grant goes to producer 0 on the first edge after `rst` falls.
- **Round-robin:** `req=4'b1111`, `din[i]=16'h0i00+k` incremented per grant, no pops → grant order 0,1,2,3,0,…; exactly 16 pushes; then `full_cr=1`, `level=16`, `fifo_push` stays 0; the FIFO's `full` rises and its contents pop out in grant order.
- **Overflow guard:** keep `req=4'b0101` for 40 cycles with no pops → 16 pushes only; no push while `level==16`; FIFO count never exceeds 16.
- **Full with simultaneous pop:** at `level==16` assert `pop_ack` for 8 cycles with `req=4'b0001` → one grant per cycle; `level` stays 16; popped data matches push order.
- **Underflow guard:** with `level==0`, pulse `pop_ack` 20 times and no requests → `level` stays 0 and no grant occurs.
- **Mid-operation reset:** assert `rst` for 1 cycle at `level==7` with requests active → next cycle `level=0`, `ptr=0`, `gnt=0`; after release, producer 0 is granted first and the FIFO shows `pndng=0` before the first new push lands.
